mmio_result_port: RTL and testbench
===================================

// Module: mmio_result_port
// PURPOSE
//  Memory-mapped responder on the mipse data bus (aluout/writedata/memwrite), in parallel with dmem.
//  Captures CPU stores to reserved addresses: console words go into a FIFO drained by a host
//  valid/ready stream; a store to the halt address latches the result and freezes cycle/stall counters.
//  Gives synthesizable hardware the end-of-run/result reporting now done by the simulation bench.
// PARAMETERS
//  DEPTH      8             console FIFO entries (power of 2, >=2)
//  HALT_ADDR  32'h0000_7fff store here: latch result, assert halt
//  PUTW_ADDR  32'h0000_7ff8 store here: push writedata into FIFO
//  STAT_ADDR  32'h0000_7ff4 load here: status word
//  CYC_ADDR   32'h0000_7ff0 load here: cycle_count
// PORTS
//  clk          in   1   clock; all state on posedge
//  rst          in   1   synchronous reset, active-high
//  addr         in   32  CPU data address (aluout), full 32-bit compare
//  wdata        in   32  CPU store data (writedata)
//  we           in   1   CPU store strobe (memwrite)
//  stall_in     in   1   core pipeline stall indicator
//  rdata        out  32  load data for mapped addresses, combinational
//  hit          out  1   addr equals STAT_ADDR or CYC_ADDR; top muxes rdata over dmem rd
//  out_data     out  32  FIFO head word
//  out_valid    out  1   FIFO non-empty
//  out_ready    in   1   host accepts out_data when out_valid&out_ready
//  halt         out  1   halt store seen (sticky)
//  result       out  32  wdata of the halt store
//  cycle_count  out  32  cycles since reset until halt
//  stall_count  out  32  stall_in cycles since reset until halt
//  overflow     out  1   sticky: push dropped because FIFO full
// BEHAVIOUR
//  Reset: out_valid=0, halt=0, overflow=0, result=0, cycle_count=0, stall_count=0, FIFO empty.
//   Reset asserted mid-run discards FIFO contents and clears all flags next edge, regardless of halt.
//  push = we & addr==PUTW_ADDR & ~halt; pop = out_valid & out_ready.
//  FIFO: show-ahead, DEPTH entries, ptr width $clog2(DEPTH)+1 (wrap bit distinguishes full/empty).
//   out_data/out_valid update one cycle after push into an empty FIFO (no bypass).
//   push & full & ~pop -> word dropped, overflow<=1; push & full & pop -> both occur, count unchanged.
//   pop when empty impossible (gated by out_valid). Order strictly FIFO.
//  Halt: we & addr==HALT_ADDR & ~halt -> next edge halt<=1, result<=wdata. Later halt/put stores
//   ignored until reset. FIFO keeps draining after halt.
//  Counters: cycle_count +1 every cycle while ~halt, including the halt-store cycle; stall_count +1
//   when stall_in & ~halt. Both saturate at 32'hffff_ffff; frozen while halt=1.
//  Loads: addr==STAT_ADDR -> rdata={16'b0, occupancy[7:0], 4'b0, overflow, halt, full, ~out_valid};
//   addr==CYC_ADDR -> rdata=cycle_count; otherwise rdata=0, hit=0. No side effects on read.
//  Stores to STAT_ADDR/CYC_ADDR ignored. Stores to other addresses ignored (dmem handles them).
//  Latency: store -> flag/FIFO visible 1 cycle; load combinational (same cycle as addr).
// STRUCTURE
//  Shared def.h: DATA_W, the four address constants, status bit positions, ENABLE/DISABLE macros.
//  One sub-module: sync_fifo (DEPTH, width DATA_W; push/pop/full/empty/occupancy/head).
//  Top: address decode, halt/result regs, saturating counters, rdata mux.
// TESTING
//  1 reset, stores to PUTW_ADDR of 1,2,3 with out_ready=0 -> out_valid=1, out_data=1, occupancy 3;
//    then out_ready=1 -> 1,2,3 in order over 3 cycles, out_valid=0 after.
//  2 DEPTH+1 pushes, out_ready=0 -> first 8 held, 9th dropped, overflow=1, STAT rdata bit3=1.
//  3 FIFO full, push 0xAA with out_ready=1 same cycle -> occupancy stays 8, 0xAA appears last.
//  4 run 50 cycles with stall_in high 7 of them, store 0x1234 to HALT_ADDR -> halt=1,
//    result=0x1234, cycle_count=51, stall_count=7, both constant for 20 more cycles.
//  5 after halt, store 0x5678 to HALT_ADDR and 9 to PUTW_ADDR -> result stays 0x1234, FIFO unchanged.
//  6 rst pulse with FIFO holding 4 words and halt=1 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/mmio_result_port_pkg.sv
// Shared constants for the mmio result port: data width, mapped
// addresses, status bit layout and the status word packer.
package mmio_result_port_pkg;

   localparam int DATA_W = 32;

   localparam logic [DATA_W-1:0] HALT_ADDR_D = 32'h0000_7fff;
   localparam logic [DATA_W-1:0] PUTW_ADDR_D = 32'h0000_7ff8;
   localparam logic [DATA_W-1:0] STAT_ADDR_D = 32'h0000_7ff4;
   localparam logic [DATA_W-1:0] CYC_ADDR_D  = 32'h0000_7ff0;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_HALT  = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_OCC   = 8;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam logic [DATA_W-1:0] CNT_MAX = '1;

   function automatic logic [DATA_W-1:0] status_word(
      input logic [7:0] occ,
      input logic       ovf,
      input logic       hlt,
      input logic       full,
      input logic       empty
   );
      logic [DATA_W-1:0] w;
      w = '0;
      w[ST_OCC+:8]  = occ;
      w[ST_OVF]     = ovf;
      w[ST_HALT]    = hlt;
      w[ST_FULL]    = full;
      w[ST_EMPTY]   = empty;
      return w;
   endfunction

endpackage

// File: rtl/mmio_result_port_if.sv
// CPU data-bus tap and host console stream of the result port.
interface mmio_result_port_if;
   import mmio_result_port_pkg::*;

   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              we;
   logic [DATA_W-1:0] rdata;
   logic              hit;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output addr,
      output wdata,
      output we,
      output out_ready,
      input  rdata,
      input  hit,
      input  out_data,
      input  out_valid
   );

   modport slave (
      input  addr,
      input  wdata,
      input  we,
      input  out_ready,
      output rdata,
      output hit,
      output out_data,
      output out_valid
   );

endinterface

// File: rtl/mmio_result_port_sync_fifo.sv
// Show-ahead synchronous FIFO; extra pointer bit separates full
// from empty. A push while full only lands if a pop frees the slot.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 32,
   localparam int AW   = $clog2(DEPTH),
   localparam int PW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          full,
   output logic          empty,
   output logic [PW-1:0] occupancy
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          wr;
   logic          rd;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
   assign occupancy = wptr - rptr;
   assign head  = mem[rptr[AW-1:0]];

   assign wr = push & (~full | pop);
   assign rd = pop & ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr) wptr <= wptr + PW'(1);
         if (rd) rptr <= rptr + PW'(1);
      end
   end

   // storage needs no reset: pointers define what is valid
   always_ff @(posedge clk) begin
      if (wr) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mmio_result_port.sv
// Memory-mapped result/console responder beside dmem: console FIFO,
// sticky halt with result capture, and saturating run counters.
module mmio_result_port
   import mmio_result_port_pkg::*;
#(
   parameter int                DEPTH     = 8,
   parameter logic [DATA_W-1:0] HALT_ADDR = HALT_ADDR_D,
   parameter logic [DATA_W-1:0] PUTW_ADDR = PUTW_ADDR_D,
   parameter logic [DATA_W-1:0] STAT_ADDR = STAT_ADDR_D,
   parameter logic [DATA_W-1:0] CYC_ADDR  = CYC_ADDR_D,
   localparam int               PW        = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   mmio_result_port_if.slave  bus,
   input  logic               stall_in,
   output logic               halt,
   output logic [DATA_W-1:0]  result,
   output logic [DATA_W-1:0]  cycle_count,
   output logic [DATA_W-1:0]  stall_count,
   output logic               overflow
);

   logic          halt_sel;
   logic          putw_sel;
   logic          stat_sel;
   logic          cyc_sel;
   logic          push;
   logic          pop;
   logic          halt_st;
   logic          full;
   logic          empty;
   logic [PW-1:0] occ;
   logic [7:0]    occ8;

   assign halt_sel = (bus.addr == HALT_ADDR);
   assign putw_sel = (bus.addr == PUTW_ADDR);
   assign stat_sel = (bus.addr == STAT_ADDR);
   assign cyc_sel  = (bus.addr == CYC_ADDR);

   assign push    = bus.we & putw_sel & ~halt;
   assign halt_st = bus.we & halt_sel & ~halt;
   assign pop     = bus.out_valid & bus.out_ready;

   sync_fifo #(
      .DEPTH (DEPTH),
      .W     (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .din       (bus.wdata),
      .pop       (pop),
      .head      (bus.out_data),
      .full      (full),
      .empty     (empty),
      .occupancy (occ)
   );

   assign bus.out_valid = ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         halt     <= DISABLE;
         result   <= '0;
         overflow <= DISABLE;
      end else begin
         if (halt_st) begin
            halt   <= ENABLE;
            result <= bus.wdata;
         end
         if (push & full & ~pop) overflow <= ENABLE;
      end
   end

   // the halt-store cycle itself still counts; halt freezes afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count <= '0;
         stall_count <= '0;
      end else if (!halt) begin
         if (cycle_count != CNT_MAX)
            cycle_count <= cycle_count + 1'b1;
         if (stall_in && stall_count != CNT_MAX)
            stall_count <= stall_count + 1'b1;
      end
   end

   assign occ8 = 8'(occ);

   always_comb begin
      bus.rdata = '0;
      bus.hit   = DISABLE;
      unique case (1'b1)
         stat_sel: begin
            bus.rdata = status_word(occ8, overflow, halt,
                                    full, empty);
            bus.hit   = ENABLE;
         end
         cyc_sel: begin
            bus.rdata = cycle_count;
            bus.hit   = ENABLE;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mmio_result_port.sv
// Directed bench for mmio_result_port: console FIFO, overflow,
// halt capture, counter freeze and mid-run reset.
module tb_mmio_result_port;

   localparam logic [31:0] HALT = 32'h0000_7fff;
   localparam logic [31:0] PUTW = 32'h0000_7ff8;
   localparam logic [31:0] STAT = 32'h0000_7ff4;
   localparam logic [31:0] CYC  = 32'h0000_7ff0;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_in;
   logic        halt;
   logic [31:0] result;
   logic [31:0] cycle_count;
   logic [31:0] stall_count;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   mmio_result_port_if bus();

   mmio_result_port dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .stall_in    (stall_in),
      .halt        (halt),
      .result      (result),
      .cycle_count (cycle_count),
      .stall_count (stall_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.we    = 1'b1;
      tick();
      bus.we    = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;
   endtask

   task automatic load(input logic [31:0] a);
      bus.addr = a;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (bus.out_valid !== 1'b0 || halt !== 1'b0 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_flags got v=%b h=%b o=%b exp 0 0 0",
                  bus.out_valid, halt, overflow);
      end
      tests++;
      if (result !== 32'h0 || cycle_count !== 32'h0 || stall_count !== 32'h0) begin
         fails++;
         $display("FAIL reset_regs got r=%h c=%h s=%h exp all 0",
                  result, cycle_count, stall_count);
      end
      load(STAT);
      tests++;
      if (bus.rdata !== 32'h0000_0001 || bus.hit !== 1'b1) begin
         fails++;
         $display("FAIL reset_stat got %h hit=%b exp 00000001 hit=1",
                  bus.rdata, bus.hit);
      end
      load(32'h0000_1000);
      tests++;
      if (bus.rdata !== 32'h0 || bus.hit !== 1'b0) begin
         fails++;
         $display("FAIL unmapped_load got %h hit=%b exp 0 hit=0",
                  bus.rdata, bus.hit);
      end
      bus.addr = '0;
   endtask

   task automatic test_order();
      store(PUTW, 32'd1);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd1) begin
         fails++;
         $display("FAIL push_latency got v=%b d=%h exp 1 00000001",
                  bus.out_valid, bus.out_data);
      end
      store(PUTW, 32'd2);
      store(PUTW, 32'd3);
      load(STAT);
      tests++;
      if (bus.rdata !== 32'h0000_0300) begin
         fails++;
         $display("FAIL order_stat got %h exp 00000300", bus.rdata);
      end
      bus.addr = '0;
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(i)) begin
            fails++;
            $display("FAIL order_pop%0d got v=%b d=%h exp 1 %h",
                     i, bus.out_valid, bus.out_data, 32'(i));
         end
         tick();
      end
      tests++;
      if (bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL order_empty got v=%b exp 0", bus.out_valid);
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 8; i++) store(PUTW, 32'(10 + i));
      tests++;
      if (overflow !== 1'b0) begin
         fails++;
         $display("FAIL ovf_early got %b exp 0", overflow);
      end
      store(PUTW, 32'd18);
      tests++;
      if (overflow !== 1'b1 || bus.out_data !== 32'd10) begin
         fails++;
         $display("FAIL ovf_flag got o=%b d=%h exp 1 0000000a",
                  overflow, bus.out_data);
      end
      load(STAT);
      tests++;
      if (bus.rdata !== 32'h0000_080a) begin
         fails++;
         $display("FAIL ovf_stat got %h exp 0000080a", bus.rdata);
      end
      bus.addr = '0;
   endtask

   task automatic test_full_pop();
      logic [31:0] exp_q [8];
      for (int i = 0; i < 7; i++) exp_q[i] = 32'(11 + i);
      exp_q[7] = 32'h0000_00aa;
      bus.out_ready = 1'b1;
      store(PUTW, 32'h0000_00aa);
      bus.out_ready = 1'b0;
      load(STAT);
      tests++;
      if (bus.rdata !== 32'h0000_080a) begin
         fails++;
         $display("FAIL fullpop_stat got %h exp 0000080a", bus.rdata);
      end
      bus.addr = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[i]) begin
            fails++;
            $display("FAIL fullpop_drain%0d got v=%b d=%h exp 1 %h",
                     i, bus.out_valid, bus.out_data, exp_q[i]);
         end
         tick();
      end
      tests++;
      if (bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL fullpop_empty got v=%b exp 0", bus.out_valid);
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_halt();
      do_reset();
      for (int i = 0; i < 50; i++) begin
         stall_in = (i == 3 || i == 10 || i == 11 || i == 20 ||
                     i == 30 || i == 40 || i == 49);
         tick();
      end
      stall_in = 1'b0;
      tests++;
      if (halt !== 1'b0 || cycle_count !== 32'd50) begin
         fails++;
         $display("FAIL prehalt got h=%b c=%0d exp 0 50",
                  halt, cycle_count);
      end
      store(HALT, 32'h0000_1234);
      tests++;
      if (halt !== 1'b1 || result !== 32'h0000_1234) begin
         fails++;
         $display("FAIL halt_capture got h=%b r=%h exp 1 00001234",
                  halt, result);
      end
      tests++;
      if (cycle_count !== 32'd51 || stall_count !== 32'd7) begin
         fails++;
         $display("FAIL halt_counts got c=%0d s=%0d exp 51 7",
                  cycle_count, stall_count);
      end
      stall_in = 1'b1;
      repeat (20) tick();
      stall_in = 1'b0;
      load(CYC);
      tests++;
      if (bus.rdata !== 32'd51 || stall_count !== 32'd7 || bus.hit !== 1'b1) begin
         fails++;
         $display("FAIL halt_frozen got c=%0d s=%0d hit=%b exp 51 7 1",
                  bus.rdata, stall_count, bus.hit);
      end
      bus.addr = '0;
   endtask

   task automatic test_after_halt();
      store(HALT, 32'h0000_5678);
      store(PUTW, 32'd9);
      store(CYC, 32'hdead_beef);
      tests++;
      if (result !== 32'h0000_1234 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL post_halt got r=%h v=%b exp 00001234 0",
                  result, bus.out_valid);
      end
      load(STAT);
      tests++;
      if (bus.rdata !== 32'h0000_0005) begin
         fails++;
         $display("FAIL post_halt_stat got %h exp 00000005", bus.rdata);
      end
      load(CYC);
      tests++;
      if (bus.rdata !== 32'd51) begin
         fails++;
         $display("FAIL post_halt_cyc got %0d exp 51", bus.rdata);
      end
      bus.addr = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 4; i++) store(PUTW, 32'(100 + i));
      store(HALT, 32'h0000_00ee);
      load(STAT);
      tests++;
      if (bus.rdata !== 32'h0000_0404) begin
         fails++;
         $display("FAIL mid_pre_stat got %h exp 00000404", bus.rdata);
      end
      bus.addr = '0;
      do_reset();
      tests++;
      if (bus.out_valid !== 1'b0 || halt !== 1'b0 || overflow !== 1'b0 ||
          result !== 32'h0 || cycle_count !== 32'h0 ||
          stall_count !== 32'h0) begin
         fails++;
         $display("FAIL mid_reset got v=%b h=%b o=%b r=%h c=%h s=%h exp all 0",
                  bus.out_valid, halt, overflow, result,
                  cycle_count, stall_count);
      end
      load(STAT);
      tests++;
      if (bus.rdata !== 32'h0000_0001) begin
         fails++;
         $display("FAIL mid_reset_stat got %h exp 00000001", bus.rdata);
      end
      bus.addr = '0;
   endtask

   initial begin
      rst           = 1'b1;
      stall_in      = 1'b0;
      bus.addr      = '0;
      bus.wdata     = '0;
      bus.we        = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      test_reset();
      test_order();
      test_overflow();
      test_full_pop();
      test_halt();
      test_after_halt();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
